// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arb_pkg: shared FSM encoding, default sizes and width helpers for the UART TX arbiter.
package uart_tx_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANTED, WAIT_DONE} state_t;
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int tmr_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
    localparam int DEF_NUM_REQ = 2;
    localparam int LOG2_NUM_REQ = idx_width(DEF_NUM_REQ);
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int TMR_W = tmr_width(DEF_TIMEOUT_CYCLES);
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side byte handshake shared by the arbiter.
interface uart_tx_arbiter_if
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]      req_pending;
    logic [NUM_REQ-1:0][7:0] req_value;
    logic [NUM_REQ-1:0]      req_write;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_grant;
    logic [NUM_REQ-1:0]      req_done;
    logic [7:0]              uart_tx_value;
    logic                    uart_tx_value_write;
    logic                    uart_tx_value_done;
    modport slave (
        input  req_pending, req_value, req_write, req_last, uart_tx_value_done,
        output req_grant, req_done, uart_tx_value, uart_tx_value_write
    );
    modport master (
        output req_pending, req_value, req_write, req_last, uart_tx_value_done,
        input  req_grant, req_done, uart_tx_value, uart_tx_value_write
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first pending index after i_ptr (circular).
module rr_select
    import uart_tx_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_pending,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    // Scan farthest-first so the closest pending index after i_ptr is written last and wins.
    always_comb begin
        o_idx = '0;
        o_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_pending[IW'((int'(i_ptr) + k) % N)]) begin
                o_idx = IW'((int'(i_ptr) + k) % N);
                o_valid = 1'b1;
            end
        end
        o_onehot = N'(o_valid) << o_idx;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of one UART TX byte port between NUM_REQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to add the idle-owner watchdog and the sticky timeout_flag output.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic clock,
    input logic arst_n,
    uart_tx_arbiter_if.slave bus
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic timeout_flag
`endif
);
    localparam int IW = idx_width(NUM_REQ);
    state_t               r_state, w_next;
    logic [IW-1:0]        r_owner, r_ptr, w_idx;
    logic [NUM_REQ-1:0]   r_grant, r_done, w_onehot, w_own_hot;
    logic [7:0]           r_value;
    logic                 r_write, r_last, w_valid, w_wr, w_drop, w_done, w_to;

    rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (
        .i_pending(bus.req_pending),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    assign w_own_hot = NUM_REQ'(1) << r_owner;
    assign w_wr      = r_state == GRANTED && bus.req_write[r_owner];
    assign w_drop    = r_state == GRANTED && !w_wr && (!bus.req_pending[r_owner] || w_to);
    assign w_done    = r_state == WAIT_DONE && bus.uart_tx_value_done;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = tmr_width(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    assign w_to = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign timeout_flag = r_timeout;
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= r_state == GRANTED ? r_cnt + 1'b1 : '0;
            r_timeout <= r_timeout | (w_drop && w_to);
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      w_next = w_valid ? GRANTED : IDLE;
            GRANTED:   w_next = w_wr ? WAIT_DONE : w_drop ? IDLE : GRANTED;
            WAIT_DONE: w_next = !w_done ? WAIT_DONE : r_last ? IDLE : GRANTED;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_grant <= '0;
            r_done  <= '0;
            r_value <= '0;
            r_write <= 1'b0;
            r_last  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= IW'(NUM_REQ - 1);
        end else begin
            r_write <= w_wr;
            r_done  <= w_done ? w_own_hot : '0;
            if (w_wr) begin
                r_value <= bus.req_value[r_owner];
                r_last  <= bus.req_last[r_owner];
            end
            if (r_state == IDLE && w_valid) begin
                r_grant <= w_onehot;
                r_owner <= w_idx;
            end
            // Every release point hands the lowest priority to the departing owner.
            if (w_drop || (w_done && r_last)) begin
                r_grant <= '0;
                r_ptr   <= r_owner;
            end
        end
    end

    assign bus.req_grant           = r_grant;
    assign bus.req_done            = r_done;
    assign bus.uart_tx_value       = r_value;
    assign bus.uart_tx_value_write = r_write;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized packet traffic checked against a round-robin reference model.
module tb_uart_tx_arbiter;
    import uart_tx_arb_pkg::*;
    localparam int N = 2;
    logic clock = 1'b0;
    logic arst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int ptr = N - 1;
    int o;
    logic [7:0] pkt [8];

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic timeout_flag;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
        .clock (clock),
        .arst_n(arst_n),
        .bus   (bus)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_flag(timeout_flag)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference arbitration rule: first pending requester strictly after the last released owner.
    function automatic int winner();
        logic [N-1:0] p;
        p = bus.req_pending;
        for (int k = 1; k <= N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic logic [N-1:0] hot(input int i);
        return N'(1) << i;
    endfunction

    task automatic clear_inputs;
        bus.req_pending = '0;
        bus.req_value = '0;
        bus.req_write = '0;
        bus.req_last = '0;
        bus.uart_tx_value_done = 1'b0;
    endtask

    task automatic do_reset;
        arst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        arst_n = 1'b1;
        ptr = N - 1;
        tick();
    endtask

    task automatic wait_grant(output int w);
        int t;
        t = 0;
        w = winner();
        while (bus.req_grant == '0 && t < 20) begin
            tick();
            t++;
        end
        chk("grant", bus.req_grant, hot(w));
    endtask

    task automatic run_pkt(input int n, input bit keep, input bit noise, output int w);
        int other;
        wait_grant(w);
        other = (w + 1) % N;
        if (noise) begin
            bus.req_write[other] = 1'b1;
            bus.req_value[other] = 8'h55;
            bus.uart_tx_value_done = 1'b1;
            tick();
            bus.req_write[other] = 1'b0;
            bus.uart_tx_value_done = 1'b0;
            chk("nonowner_wr", bus.uart_tx_value_write, 0);
            chk("stray_done", bus.req_done, 0);
            chk("grant_hold", bus.req_grant, hot(w));
        end
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(2)) tick();
            bus.req_value[w] = pkt[b];
            bus.req_last[w] = b == n - 1;
            bus.req_write[w] = 1'b1;
            tick();
            bus.req_write[w] = 1'b0;
            bus.req_last[w] = 1'b0;
            chk("uart_wr", bus.uart_tx_value_write, 1);
            chk("uart_val", bus.uart_tx_value, pkt[b]);
            if (noise) begin
                bus.req_value[w] = 8'h99;
                bus.req_write[w] = 1'b1;
                tick();
                bus.req_write[w] = 1'b0;
                chk("wait_wr", bus.uart_tx_value_write, 0);
            end
            repeat ($urandom_range(3)) begin
                tick();
                chk("early_done", bus.req_done, 0);
            end
            bus.uart_tx_value_done = 1'b1;
            bus.req_write[w] = noise;
            bus.req_value[w] = 8'hEE;
            tick();
            bus.uart_tx_value_done = 1'b0;
            bus.req_write[w] = 1'b0;
            chk("req_done", bus.req_done, hot(w));
            chk("drop_wr", bus.uart_tx_value_write, 0);
            chk("grant_after_done", bus.req_grant, b == n - 1 ? '0 : hot(w));
        end
        bus.req_pending[w] = keep;
        ptr = w;
    endtask

    task automatic abort_pkt(output int w);
        wait_grant(w);
        bus.req_pending[w] = 1'b0;
        tick();
        chk("abort_grant", bus.req_grant, 0);
        ptr = w;
    endtask

    initial begin
        clear_inputs();
        repeat (2) tick();
        chk("rst_grant", bus.req_grant, 0);
        chk("rst_done", bus.req_done, 0);
        chk("rst_value", bus.uart_tx_value, 0);
        chk("rst_write", bus.uart_tx_value_write, 0);
        arst_n = 1'b1;
        tick();

        pkt[0] = 8'h41; pkt[1] = 8'h42; pkt[2] = 8'h43;
        bus.req_pending = 2'b01;
        run_pkt(3, 1'b0, 1'b0, o);
        chk("t1_owner", o, 0);

        do_reset();
        bus.req_pending = 2'b11;
        pkt[0] = 8'h10; pkt[1] = 8'h11;
        run_pkt(2, 1'b1, 1'b0, o);
        chk("t2_first", o, 0);
        pkt[0] = 8'h20; pkt[1] = 8'h21;
        run_pkt(2, 1'b1, 1'b1, o);
        chk("t2_second", o, 1);
        pkt[0] = 8'h30; pkt[1] = 8'h31;
        run_pkt(2, 1'b0, 1'b0, o);
        chk("t2_third", o, 0);
        pkt[0] = 8'h98; pkt[1] = 8'h9A;
        run_pkt(2, 1'b0, 1'b1, o);
        chk("t4_owner", o, 1);

        bus.req_pending = 2'b11;
        abort_pkt(o);
        chk("t5_abort_owner", o, 0);
        pkt[0] = 8'h5A;
        run_pkt(1, 1'b0, 1'b0, o);
        chk("t5_next_owner", o, 1);

        repeat (60) begin
            bus.req_pending = bus.req_pending | N'($urandom);
            if (bus.req_pending == '0) bus.req_pending[$urandom_range(N - 1)] = 1'b1;
            for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
            if ($urandom_range(5) == 0) begin
                abort_pkt(o);
                bus.req_pending[o] = 1'($urandom);
            end else begin
                run_pkt($urandom_range(1, 4), 1'($urandom), 1'($urandom), o);
            end
        end

`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int t;
            do_reset();
            chk("flag_reset", timeout_flag, 0);
            bus.req_pending = 2'b01;
            wait_grant(o);
            t = 0;
            while (bus.req_grant != '0 && t < 20) begin
                tick();
                t++;
            end
            chk("timeout_cycles", t, 8);
            chk("timeout_flag", timeout_flag, 1);
            bus.req_pending = '0;
            ptr = o;
            tick();
        end
`endif

        do_reset();
        bus.req_pending = 2'b01;
        wait_grant(o);
        bus.req_value[o] = 8'hC3;
        bus.req_write[o] = 1'b1;
        tick();
        bus.req_write[o] = 1'b0;
        chk("mid_wr", bus.uart_tx_value_write, 1);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_grant", bus.req_grant, 0);
        chk("mid_rst_write", bus.uart_tx_value_write, 0);
        chk("mid_rst_value", bus.uart_tx_value, 0);
        chk("mid_rst_done", bus.req_done, 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("mid_rst_flag", timeout_flag, 0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
